// File: rtl/hazard_scoreboard.sv
// Stall/forward controller tracking in-flight destination registers, plus a mult/div busy counter.
// Define HAZARD_SCOREBOARD_STATS_EN to add the stall_cycles / md_stall_cycles counters.
`timescale 1ns/1ps

module hazard_scoreboard #(
   parameter int STAGES = 3,
   parameter int REG_W  = 5,
   parameter int T_W    = 2,
   parameter int SEL_W  = 2,
   parameter int MD_LAT = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               d_valid,
   input  logic [REG_W-1:0]   d_rs,
   input  logic [REG_W-1:0]   d_rt,
   input  logic [T_W-1:0]     d_tuse_rs,
   input  logic [T_W-1:0]     d_tuse_rt,
   input  logic [REG_W-1:0]   d_wreg,
   input  logic [T_W-1:0]     d_tnew,
   input  logic               d_md_start,
   input  logic               d_md_use,
   input  logic [STAGES-1:0]  flush,
   output logic               stall,
   output logic [SEL_W-1:0]   fwd_rs_sel,
   output logic [SEL_W-1:0]   fwd_rt_sel,
   output logic               md_busy
`ifdef HAZARD_SCOREBOARD_STATS_EN
   ,
   output logic [31:0]        stall_cycles,
   output logic [31:0]        md_stall_cycles
`endif
);

   localparam int MD_W = $clog2(MD_LAT + 1);

   logic [STAGES-1:0] valid_q, valid_d;
   logic [REG_W-1:0]  wreg_q [STAGES];
   logic [REG_W-1:0]  wreg_d [STAGES];
   logic [T_W-1:0]    tnew_q [STAGES];
   logic [T_W-1:0]    tnew_d [STAGES];
   logic [MD_W-1:0]   md_count_q, md_count_d;

   logic [STAGES-1:0] match_rs, match_rt;
   logic              reg_stall;
   logic              md_stall;
   logic              md_accept;
   logic              flush_unused;

   // The entry in the last slot is discarded on the next edge, so flushing it has nothing to clear.
   assign flush_unused = flush[STAGES-1];

   always_comb begin
      match_rs   = '0;
      match_rt   = '0;
      reg_stall  = 1'b0;
      fwd_rs_sel = '0;
      fwd_rt_sel = '0;
      for (int k = 0; k < STAGES; k++) begin
         match_rs[k] = d_valid && valid_q[k] && (wreg_q[k] != '0) && (wreg_q[k] == d_rs);
         match_rt[k] = d_valid && valid_q[k] && (wreg_q[k] != '0) && (wreg_q[k] == d_rt);
         if (match_rs[k] && (tnew_q[k] > d_tuse_rs)) reg_stall = 1'b1;
         if (match_rt[k] && (tnew_q[k] > d_tuse_rt)) reg_stall = 1'b1;
      end
      // Walk oldest to youngest so the youngest match has the final say.
      for (int k = STAGES - 1; k >= 0; k--) begin
         if (match_rs[k]) fwd_rs_sel = (tnew_q[k] == '0) ? SEL_W'(k + 1) : '0;
         if (match_rt[k]) fwd_rt_sel = (tnew_q[k] == '0) ? SEL_W'(k + 1) : '0;
      end
   end

   always_comb begin
      md_stall  = d_valid && d_md_use && (md_count_q != '0);
      stall     = reg_stall | md_stall;
      md_busy   = (md_count_q != '0);
      md_accept = d_valid && d_md_start && !stall;
   end

   always_comb begin
      valid_d    = '0;
      valid_d[0] = d_valid && !stall;
      wreg_d[0]  = valid_d[0] ? d_wreg : '0;
      tnew_d[0]  = valid_d[0] ? d_tnew : '0;
      for (int k = 1; k < STAGES; k++) begin
         valid_d[k] = valid_q[k-1] && !flush[k-1];
         wreg_d[k]  = wreg_q[k-1];
         tnew_d[k]  = (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - 1'b1;
      end
   end

   always_comb begin
      md_count_d = md_count_q;
      if (md_accept)
         md_count_d = MD_W'(MD_LAT);
      else if (md_count_q != '0)
         md_count_d = md_count_q - 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q    <= '0;
         md_count_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            wreg_q[k] <= '0;
            tnew_q[k] <= '0;
         end
      end else begin
         valid_q    <= valid_d;
         md_count_q <= md_count_d;
         for (int k = 0; k < STAGES; k++) begin
            wreg_q[k] <= wreg_d[k];
            tnew_q[k] <= tnew_d[k];
         end
      end
   end

`ifdef HAZARD_SCOREBOARD_STATS_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [31:0] md_stall_cycles_q, md_stall_cycles_d;

   // Both counters saturate rather than wrap.
   always_comb begin
      stall_cycles_d    = stall_cycles_q;
      md_stall_cycles_d = md_stall_cycles_q;
      if (stall && (stall_cycles_q != '1))
         stall_cycles_d = stall_cycles_q + 32'd1;
      if (md_stall && (md_stall_cycles_q != '1))
         md_stall_cycles_d = md_stall_cycles_q + 32'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cycles_q    <= '0;
         md_stall_cycles_q <= '0;
      end else begin
         stall_cycles_q    <= stall_cycles_d;
         md_stall_cycles_q <= md_stall_cycles_d;
      end
   end

   assign stall_cycles    = stall_cycles_q;
   assign md_stall_cycles = md_stall_cycles_q;
`endif

endmodule
